// File: rtl/signature_analyzer_mc.sv
// Multi-channel frame-aware MISR signature analyzer with expected-signature compare and overrun flag.
// Latency: a sample accepted on edge N is in signature_o after edge N; done_o rises with the last sample's update.
// Backpressure: none; one sample per cycle accepted in RUN while en_i is high, en_i low stalls the frame.
module signature_analyzer_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int SIG_WIDTH = 24,
  parameter int NUM_CH = 3,
  parameter logic [SIG_WIDTH-1:0] POLY = 24'h00001B,
  parameter logic [SIG_WIDTH-1:0] SEED = 24'h000000,
  parameter int LEN_WIDTH = 16,
  localparam int SEL_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [LEN_WIDTH-1:0]         frame_len_i,
  input  logic                         valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  input  logic [SEL_WIDTH-1:0]         rd_sel_i,
  input  logic [SIG_WIDTH-1:0]         expected_i,
  output logic [SIG_WIDTH-1:0]         signature_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         match_o,
  output logic                         overrun_o,
  output logic [LEN_WIDTH-1:0]         count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state;
  logic [SIG_WIDTH-1:0] sig [NUM_CH];
  logic [LEN_WIDTH-1:0] count;
  logic [LEN_WIDTH-1:0] len;
  logic                 overrun;

  logic                 start_ok;
  logic                 take;
  logic [LEN_WIDTH-1:0] count_nxt;
  logic [SIG_WIDTH-1:0] sig_sel;
  logic                 sel_ok;

  // One MISR step: shift left, fold the dropped MSB back through POLY, mix in the sample.
  function automatic logic [SIG_WIDTH-1:0] misr_next(input logic [SIG_WIDTH-1:0] s,
                                                     input logic [DATA_WIDTH-1:0] d);
    return {s[SIG_WIDTH-2:0], 1'b0} ^ (s[SIG_WIDTH-1] ? POLY : '0) ^ SIG_WIDTH'(d);
  endfunction

  // A start is only honoured outside RUN, so a frame cannot be restarted mid-way.
  assign start_ok  = start_i && en_i && (state != ST_RUN);
  assign take      = (state == ST_RUN) && valid_i && en_i;
  // count < len holds throughout RUN, so this increment never wraps.
  assign count_nxt = count + LEN_WIDTH'(1);

  // Frame control: state, sample counter, latched length and sticky overrun.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      count   <= '0;
      len     <= '0;
      overrun <= 1'b0;
    end else if (clear_i) begin
      state   <= ST_IDLE;
      count   <= '0;
      overrun <= 1'b0;
    end else if (start_ok) begin
      len     <= frame_len_i;
      count   <= '0;
      overrun <= 1'b0;
      state   <= (frame_len_i == '0) ? ST_DONE : ST_RUN;
    end else if (take) begin
      count <= count_nxt;
      if (count_nxt == len) begin
        state <= ST_DONE;
      end
    end else if ((state == ST_DONE) && valid_i) begin
      overrun <= 1'b1;
    end
  end

  // Per-channel signature registers; all channels advance together on an accepted sample.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        sig[k] <= SEED;
      end
    end else if (clear_i || start_ok) begin
      for (int k = 0; k < NUM_CH; k++) begin
        sig[k] <= SEED;
      end
    end else if (take) begin
      for (int k = 0; k < NUM_CH; k++) begin
        sig[k] <= misr_next(sig[k], data_i[k*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  // Readback mux; an out-of-range channel select reads as zero and never matches.
  always_comb begin
    sig_sel = '0;
    sel_ok  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(rd_sel_i) == k) begin
        sig_sel = sig[k];
        sel_ok  = 1'b1;
      end
    end
  end

  assign signature_o = sig_sel;
  assign busy_o      = (state == ST_RUN);
  assign done_o      = (state == ST_DONE);
  assign match_o     = done_o && sel_ok && (sig_sel == expected_i);
  assign overrun_o   = overrun;
  assign count_o     = count;

endmodule

// File: tb/tb_signature_analyzer_mc.sv
module tb_signature_analyzer_mc;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        en_i;
  logic        clear_i;
  logic        start_i;
  logic [15:0] frame_len_i;
  logic        valid_i;
  logic [23:0] data_i;
  logic [1:0]  rd_sel_i;
  logic [23:0] expected_i;

  logic [23:0] signature_o, s2_signature;
  logic        busy_o, done_o, match_o, overrun_o;
  logic        s2_busy, s2_done, s2_match, s2_overrun;
  logic [15:0] count_o, s2_count;

  int total = 0;
  int bad = 0;

  localparam logic [23:0] POLY = 24'h00001B;

  signature_analyzer_mc dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .clear_i(clear_i), .start_i(start_i),
    .frame_len_i(frame_len_i), .valid_i(valid_i), .data_i(data_i), .rd_sel_i(rd_sel_i),
    .expected_i(expected_i), .signature_o(signature_o), .busy_o(busy_o), .done_o(done_o),
    .match_o(match_o), .overrun_o(overrun_o), .count_o(count_o)
  );

  signature_analyzer_mc #(.SEED(24'h800000)) dut_seed (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .clear_i(clear_i), .start_i(start_i),
    .frame_len_i(frame_len_i), .valid_i(valid_i), .data_i(data_i), .rd_sel_i(rd_sel_i),
    .expected_i(expected_i), .signature_o(s2_signature), .busy_o(s2_busy), .done_o(s2_done),
    .match_o(s2_match), .overrun_o(s2_overrun), .count_o(s2_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; frame_len_i = '0;
    valid_i = 1'b0; data_i = '0; rd_sel_i = '0; expected_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
  endtask

  // Polynomial view of one MISR step: multiply by x modulo x^24 + POLY, then add the sample.
  function automatic logic [23:0] gf_step(input logic [23:0] s, input logic [23:0] d);
    logic [24:0] t;
    t = {1'b0, s} << 1;
    if (t[24]) t = t ^ {1'b1, POLY};
    return t[23:0] ^ d;
  endfunction

  typedef struct {
    logic        clr, st, en, vl;
    logic [15:0] len;
    logic [23:0] dat;
    logic [1:0]  sel;
    logic [23:0] exp;
    logic [23:0] e_sig;
    logic        e_busy, e_done, e_match, e_ovr;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic clr, st, en, vl, input logic [15:0] len,
                              input logic [23:0] dat, input logic [1:0] sel, input logic [23:0] exp,
                              input logic [23:0] e_sig, input logic e_busy, e_done, e_match, e_ovr,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.clr = clr; v.st = st; v.en = en; v.vl = vl; v.len = len; v.dat = dat; v.sel = sel; v.exp = exp;
    v.e_sig = e_sig; v.e_busy = e_busy; v.e_done = e_done; v.e_match = e_match; v.e_ovr = e_ovr;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t tbl [22];

  // reference model state
  int          mst;   // 0 idle, 1 run, 2 done
  logic [23:0] msig [3];
  logic [15:0] mcnt, mlen;
  logic        movr;

  task automatic model_reset();
    mst = 0; mcnt = '0; mlen = '0; movr = 1'b0;
    for (int k = 0; k < 3; k++) msig[k] = 24'h0;
  endtask

  task automatic model_clock();
    if (clear_i) begin
      mst = 0; mcnt = 0; movr = 0;
      for (int k = 0; k < 3; k++) msig[k] = 24'h0;
    end else if (start_i && en_i && mst != 1) begin
      for (int k = 0; k < 3; k++) msig[k] = 24'h0;
      mcnt = 0; mlen = frame_len_i; movr = 0;
      mst = (frame_len_i == 0) ? 2 : 1;
    end else if (mst == 1 && valid_i && en_i) begin
      for (int k = 0; k < 3; k++) msig[k] = gf_step(msig[k], {16'h0, data_i[k*8 +: 8]});
      mcnt = mcnt + 1;
      if (mcnt == mlen) mst = 2;
    end else if (mst == 2 && valid_i) begin
      movr = 1;
    end
  endtask

  function automatic logic [23:0] model_sel(input logic [1:0] sel);
    return (sel < 3) ? msig[sel] : 24'h0;
  endfunction

  initial begin
    logic [23:0] ms;
    reset_i = 1'b1;
    idle_inputs();
    #1;
    chk("reset.sig", signature_o, 0);
    chk("reset.busy", busy_o, 0);
    chk("reset.done", done_o, 0);
    chk("reset.count", count_o, 0);
    chk("reset.ovr", overrun_o, 0);
    step();
    reset_i = 1'b0;

    tbl[0]  = mk(0,0,1,1,0,24'h010203,0,0,       24'h0,     0,0,0,0,0);
    tbl[1]  = mk(0,1,1,0,2,0,0,0,                24'h0,     1,0,0,0,0);
    tbl[2]  = mk(0,0,1,1,0,24'h000001,0,0,       24'h1,     1,0,0,0,1);
    tbl[3]  = mk(0,0,1,1,0,24'h000002,0,0,       24'h0,     0,1,1,0,2);
    tbl[4]  = mk(0,0,1,0,0,0,0,24'h5,            24'h0,     0,1,0,0,2);
    tbl[5]  = mk(0,1,1,0,1,0,0,0,                24'h0,     1,0,0,0,0);
    tbl[6]  = mk(0,0,1,1,0,24'hFFA005,0,24'h5,   24'h5,     0,1,1,0,1);
    tbl[7]  = mk(0,0,1,0,0,0,1,24'hA0,           24'hA0,    0,1,1,0,1);
    tbl[8]  = mk(0,0,1,0,0,0,2,0,                24'hFF,    0,1,0,0,1);
    tbl[9]  = mk(0,0,1,0,0,0,3,0,                24'h0,     0,1,0,0,1);
    tbl[10] = mk(0,0,1,1,0,24'h777777,0,0,       24'h5,     0,1,0,1,1);
    tbl[11] = mk(0,1,1,0,3,0,0,0,                24'h0,     1,0,0,0,0);
    tbl[12] = mk(0,0,1,1,0,24'h000003,0,0,       24'h3,     1,0,0,0,1);
    tbl[13] = mk(0,0,0,1,0,24'h000007,0,0,       24'h3,     1,0,0,0,1);
    tbl[14] = mk(0,0,0,1,0,24'h000007,0,0,       24'h3,     1,0,0,0,1);
    tbl[15] = mk(0,0,1,1,0,24'h000004,0,0,       24'h2,     1,0,0,0,2);
    tbl[16] = mk(0,1,1,1,5,24'h000001,0,24'h5,   24'h5,     0,1,1,0,3);
    tbl[17] = mk(0,1,1,0,0,0,0,0,                24'h0,     0,1,1,0,0);
    tbl[18] = mk(1,1,1,0,2,0,0,0,                24'h0,     0,0,0,0,0);
    tbl[19] = mk(0,1,1,0,2,0,0,0,                24'h0,     1,0,0,0,0);
    tbl[20] = mk(0,0,1,1,0,24'h000080,0,0,       24'h80,    1,0,0,0,1);
    tbl[21] = mk(1,0,1,1,0,0,0,0,                24'h0,     0,0,0,0,0);

    foreach (tbl[i]) begin
      clear_i = tbl[i].clr; start_i = tbl[i].st; en_i = tbl[i].en; valid_i = tbl[i].vl;
      frame_len_i = tbl[i].len; data_i = tbl[i].dat; rd_sel_i = tbl[i].sel; expected_i = tbl[i].exp;
      step();
      chk($sformatf("v%0d.sig", i), signature_o, tbl[i].e_sig);
      chk($sformatf("v%0d.busy", i), busy_o, tbl[i].e_busy);
      chk($sformatf("v%0d.done", i), done_o, tbl[i].e_done);
      chk($sformatf("v%0d.match", i), match_o, tbl[i].e_match);
      chk($sformatf("v%0d.ovr", i), overrun_o, tbl[i].e_ovr);
      chk($sformatf("v%0d.count", i), count_o, tbl[i].e_cnt);
    end

    // Non-zero seed: the seed MSB feeds back through POLY on the first sample.
    do_reset();
    chk("seed.idle", s2_signature, 24'h800000);
    start_i = 1; frame_len_i = 1;
    step();
    start_i = 0; valid_i = 1; data_i = 24'h0;
    step();
    valid_i = 0;
    chk("seed.sig", s2_signature, 24'h00001B);
    chk("seed.done", s2_done, 1);
    expected_i = 24'h00001B;
    #1;
    chk("seed.match1", s2_match, 1);
    expected_i = 24'h00001C;
    #1;
    chk("seed.match0", s2_match, 0);

    // Asynchronous reset in the middle of a frame.
    do_reset();
    start_i = 1; frame_len_i = 4;
    step();
    start_i = 0; valid_i = 1; data_i = 24'h112233;
    step();
    step();
    chk("midrun.busy_before", busy_o, 1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("midrun.busy", busy_o, 0);
    chk("midrun.count", count_o, 0);
    chk("midrun.sig", signature_o, 0);
    chk("midrun.done", done_o, 0);
    chk("midrun.seed_sig", s2_signature, 24'h800000);
    step();
    reset_i = 1'b0;
    idle_inputs();
    step();

    // Randomized traffic against the model.
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      clear_i = ($urandom_range(0, 99) < 2);
      start_i = ($urandom_range(0, 99) < 8);
      en_i = ($urandom_range(0, 99) < 85);
      valid_i = ($urandom_range(0, 99) < 75);
      frame_len_i = 16'($urandom_range(0, 6));
      data_i = 24'($urandom);
      model_clock();
      step();
      rd_sel_i = 2'($urandom_range(0, 3));
      ms = model_sel(rd_sel_i);
      expected_i = ($urandom_range(0, 1) == 1) ? ms : 24'($urandom);
      #1;
      chk($sformatf("r%0d.sig", n), signature_o, ms);
      chk($sformatf("r%0d.busy", n), busy_o, mst == 1);
      chk($sformatf("r%0d.done", n), done_o, mst == 2);
      chk($sformatf("r%0d.match", n), match_o, (mst == 2) && (rd_sel_i < 3) && (ms == expected_i));
      chk($sformatf("r%0d.ovr", n), overrun_o, movr);
      chk($sformatf("r%0d.count", n), count_o, mcnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
